// File: rtl/pipe_skid_reg.sv
// Two-entry skid register between pipeline stages: 1-cycle latency, full throughput.
// in_ready is decoded from registered state only, so upstream sees no combinational path from out_ready.
module pipe_skid_reg #(
   parameter int               WIDTH     = 64,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       count
);

   localparam logic [1:0] S_EMPTY = 2'd0;
   localparam logic [1:0] S_ONE   = 2'd1;
   localparam logic [1:0] S_TWO   = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             acc, pop;

   assign in_ready  = (state_q != S_TWO);
   assign out_valid = (state_q != S_EMPTY);
   assign out_data  = (state_q == S_EMPTY) ? RESET_VAL : main_q;
   assign count     = state_q;

   assign acc = in_valid & in_ready;
   assign pop = out_valid & out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = S_EMPTY;
         main_d  = RESET_VAL;
         skid_d  = RESET_VAL;
      end else begin
         case (state_q)
            S_EMPTY: begin
               if (acc) begin
                  main_d  = in_data;
                  state_d = S_ONE;
               end
            end
            S_ONE: begin
               if (acc && pop) begin
                  main_d = in_data;
               end else if (acc) begin
                  skid_d  = in_data;
                  state_d = S_TWO;
               end else if (pop) begin
                  state_d = S_EMPTY;
               end
            end
            S_TWO: begin
               // in_ready is low here, so only a pop can happen
               if (pop) begin
                  main_d  = skid_q;
                  state_d = S_ONE;
               end
            end
            default: state_d = S_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_EMPTY;
         main_q  <= RESET_VAL;
         skid_q  <= RESET_VAL;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

endmodule
